// File: rtl/bd_mode_scheduler.sv
// Backlight block scheduler: selects a dimming mode per frame, lets the
// selector settle, snapshots all block values and streams them out bytewise.
module bd_mode_scheduler #(
    parameter int NUM_BLOCKS = 24,
    parameter int SETTLE_CYC = 2
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iVSync,
    input  logic [1:0]              iModeReq,
    output logic [1:0]              oModeSel,
    input  logic [8*NUM_BLOCKS-1:0] iBlockData,
    output logic [7:0]              oByteData,
    output logic                    oByteValid,
    input  logic                    iByteReady,
    output logic                    oBusy,
    output logic                    oFrameDone,
    output logic                    oOverrun
);

    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]              r_state;
    logic [1:0]              r_mode;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [8*NUM_BLOCKS-1:0] r_shadow;
    logic                    r_overrun;
    logic [7:0]              w_byte;

    assign w_byte = r_shadow[{r_idx, 3'b000} +: 8];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'b00;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_overrun <= 1'b0;
        end else begin
            // A frame start seen outside IDLE (DONE included) is only flagged.
            if (iVSync && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (iVSync) begin
                        r_mode  <= iModeReq;
                        r_cnt   <= CNT_INIT;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_shadow <= iBlockData;
                    r_idx    <= '0;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (iByteReady) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oModeSel   = r_mode;
    assign oByteData  = w_byte;
    assign oByteValid = (r_state == S_SEND);
    assign oFrameDone = (r_state == S_DONE);
    assign oBusy      = (r_state != S_IDLE);
    assign oOverrun   = r_overrun;

endmodule
